// File: rtl/mul_div_unit_if.sv
// Request/response bundle between the EX stage and the multiply/divide unit.
// The master side issues operations; the slave side is the unit itself.
interface mul_div_unit_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  start;
    logic [2:0]            op;
    logic [DATA_WIDTH-1:0] data_a;
    logic [DATA_WIDTH-1:0] data_b;
    logic                  flush;
    logic                  busy;
    logic                  done;
    logic [DATA_WIDTH-1:0] hi;
    logic [DATA_WIDTH-1:0] lo;

    modport master (
        output start, op, data_a, data_b, flush,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, op, data_a, data_b, flush,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/mul_div_unit.sv
// Iterative multiply/divide unit with the HI/LO register pair.
// Radix-2 shift-add multiply and restoring divide, one bit per cycle, run on
// operand magnitudes; signs are restored in a final fix-up cycle.
module mul_div_unit #(
    parameter int         DATA_WIDTH = 32,
    parameter logic [2:0] OP_MULT    = 3'b000,
    parameter logic [2:0] OP_MULTU   = 3'b001,
    parameter logic [2:0] OP_DIV     = 3'b010,
    parameter logic [2:0] OP_DIVU    = 3'b011,
    parameter logic [2:0] OP_MTHI    = 3'b100,
    parameter logic [2:0] OP_MTLO    = 3'b101
) (
    input logic           clk,
    input logic           rst_n,
    mul_div_unit_if.slave bus
);
    localparam int W2    = 2 * DATA_WIDTH;
    localparam int CNT_W = $clog2(DATA_WIDTH) + 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DATA_WIDTH);

    typedef enum logic [1:0] {S_IDLE, S_PREP, S_RUN, S_FIX} state_t;

    state_t                r_state;
    logic [CNT_W-1:0]      r_cnt;
    logic [W2:0]           r_acc;      // {upper (remainder/partial sum), lower (multiplier/quotient)}
    logic [DATA_WIDTH-1:0] r_a;        // original dividend, kept for the divide-by-zero result
    logic [DATA_WIDTH-1:0] r_b;        // multiplicand/divisor, magnitude after PREP
    logic                  r_is_div;
    logic                  r_signed;
    logic                  r_neg_res;  // product / quotient must be negated
    logic                  r_neg_rem;  // remainder must be negated (follows dividend)
    logic                  r_div_zero;
    logic [DATA_WIDTH-1:0] r_hi;
    logic [DATA_WIDTH-1:0] r_lo;
    logic                  r_busy;
    logic                  r_done;

    logic                  w_is_muldiv;
    logic                  w_op_signed;
    logic [DATA_WIDTH-1:0] w_abs_a;
    logic [DATA_WIDTH-1:0] w_abs_b;
    logic [DATA_WIDTH:0]   w_sum;
    logic [W2:0]           w_shl;
    logic [DATA_WIDTH+1:0] w_trial;
    logic [W2:0]           w_acc_step;
    logic [W2-1:0]         w_prod;
    logic [DATA_WIDTH-1:0] w_quo;
    logic [DATA_WIDTH-1:0] w_rem;

    // Operation decode, operand magnitudes and one iteration of the datapath.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        w_is_muldiv = 1'b0;
        w_op_signed = 1'b0;
        w_acc_step  = '0;
        if (bus.op == OP_MULT || bus.op == OP_MULTU || bus.op == OP_DIV || bus.op == OP_DIVU)
            w_is_muldiv = 1'b1;
        if (bus.op == OP_MULT || bus.op == OP_DIV)
            w_op_signed = 1'b1;

        w_abs_a = (r_signed && r_a[DATA_WIDTH-1]) ? ('0 - r_a) : r_a;
        w_abs_b = (r_signed && r_b[DATA_WIDTH-1]) ? ('0 - r_b) : r_b;

        // Multiply: conditionally add the multiplicand to the upper half, then shift right.
        w_sum = r_acc[W2:DATA_WIDTH] + (r_acc[0] ? {1'b0, r_b} : '0);
        // Divide: shift left, trial-subtract the divisor, keep the difference if no borrow.
        w_shl   = {r_acc[W2-1:0], 1'b0};
        w_trial = {1'b0, w_shl[W2:DATA_WIDTH]} - {2'b00, r_b};

        if (r_is_div)
            w_acc_step = w_trial[DATA_WIDTH+1] ? w_shl
                                               : {w_trial[DATA_WIDTH:0], w_shl[DATA_WIDTH-1:1], 1'b1};
        else
            w_acc_step = {1'b0, w_sum, r_acc[DATA_WIDTH-1:1]};

        w_prod = r_acc[W2-1:0];
        w_quo  = r_acc[DATA_WIDTH-1:0];
        w_rem  = r_acc[W2-1:DATA_WIDTH];
    end

    // Control FSM with the datapath registers and registered busy/done/HI/LO.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: datapath registers are reset along with the FSM so no X ever reaches HI/LO.
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_acc      <= '0;
            r_a        <= '0;
            r_b        <= '0;
            r_is_div   <= 1'b0;
            r_signed   <= 1'b0;
            r_neg_res  <= 1'b0;
            r_neg_rem  <= 1'b0;
            r_div_zero <= 1'b0;
            r_hi       <= '0;
            r_lo       <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            r_done <= 1'b0;
            if (r_state == S_IDLE) begin
                if (bus.start && !bus.flush) begin
                    if (w_is_muldiv) begin
                        r_state    <= S_PREP;
                        r_busy     <= 1'b1;
                        r_a        <= bus.data_a;
                        r_b        <= bus.data_b;
                        r_is_div   <= (bus.op == OP_DIV || bus.op == OP_DIVU);
                        r_signed   <= w_op_signed;
                        r_neg_res  <= w_op_signed & (bus.data_a[DATA_WIDTH-1] ^ bus.data_b[DATA_WIDTH-1]);
                        r_neg_rem  <= w_op_signed & bus.data_a[DATA_WIDTH-1];
                        r_div_zero <= (bus.data_b == '0);
                    end else if (bus.op == OP_MTHI) begin
                        r_hi <= bus.data_a;
                    end else if (bus.op == OP_MTLO) begin
                        r_lo <= bus.data_a;
                    end
                end
            end else if (bus.flush) begin
                r_state <= S_IDLE;
                r_busy  <= 1'b0;
            end else begin
                case (r_state)
                    S_PREP: begin
                        r_acc   <= {{(DATA_WIDTH+1){1'b0}}, w_abs_a};
                        r_b     <= w_abs_b;
                        r_cnt   <= CNT_LOAD;
                        r_state <= S_RUN;
                    end
                    S_RUN: begin
                        r_acc <= w_acc_step;
                        r_cnt <= r_cnt - 1'b1;
                        if (r_cnt == CNT_W'(1))
                            r_state <= S_FIX;
                    end
                    S_FIX: begin
                        if (!r_is_div) begin
                            {r_hi, r_lo} <= r_neg_res ? ('0 - w_prod) : w_prod;
                        end else if (r_div_zero) begin
                            r_lo <= '1;
                            r_hi <= r_a;
                        end else begin
                            r_lo <= r_neg_res ? ('0 - w_quo) : w_quo;
                            r_hi <= r_neg_rem ? ('0 - w_rem) : w_rem;
                        end
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                    default: begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.busy = r_busy;
    assign bus.done = r_done;
    assign bus.hi   = r_hi;
    assign bus.lo   = r_lo;
endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: directed corner cases, flush/abort,
// async reset and randomized operations against an arithmetic reference model.
module tb_mul_div_unit;
    localparam int DW = 32;
    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    mul_div_unit_if #(.DATA_WIDTH(DW)) bus ();

    mul_div_unit #(.DATA_WIDTH(DW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    logic [DW-1:0] m_hi = '0;
    logic [DW-1:0] m_lo = '0;

    // Reference: MIPS HI/LO result straight from integer arithmetic.
    function automatic logic [2*DW-1:0] ref_model(input logic [2:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b);
        longint          sa, sb;
        longint unsigned ua, ub;
        int              ia, ib, q, r;
        logic [DW-1:0]   uq, ur;
        case (op)
            OP_MULT: begin
                sa = longint'($signed(a));
                sb = longint'($signed(b));
                return 64'(sa * sb);
            end
            OP_MULTU: begin
                ua = {32'd0, a};
                ub = {32'd0, b};
                return 64'(ua * ub);
            end
            OP_DIV: begin
                if (b == 0) return {a, 32'hFFFF_FFFF};
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
                ia = a;
                ib = b;
                q  = ia / ib;
                r  = ia % ib;
                return {32'(r), 32'(q)};
            end
            default: begin
                if (b == 0) return {a, 32'hFFFF_FFFF};
                uq = a / b;
                ur = a % b;
                return {ur, uq};
            end
        endcase
    endfunction

    function automatic logic [DW-1:0] pick_operand();
        case ($urandom_range(0, 9))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'h0000_0001;
            4:       return 32'h7FFF_FFFF;
            5:       return 32'($urandom_range(0, 15));
            default: return 32'($urandom());
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one mul/div and follow it to its done cycle; returns in the done cycle.
    task automatic run_op(input logic [2:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b, input string name);
        logic [2*DW-1:0] exp;
        int busy_err, done_err;
        exp         = ref_model(op, a, b);
        bus.start   = 1'b1;
        bus.op      = op;
        bus.data_a  = a;
        bus.data_b  = b;
        tick();
        bus.start = 1'b0;
        busy_err  = 0;
        done_err  = (bus.done !== 1'b0) ? 1 : 0;
        for (int k = 1; k <= DW + 1; k++) begin
            tick();
            if (bus.busy !== 1'b1) busy_err++;
            if (bus.done !== 1'b0) done_err++;
        end
        tick();
        total++;
        if (busy_err != 0) begin
            bad++;
            $display("FAIL %s busy_window: low in %0d cycles, required 0", name, busy_err);
        end
        total++;
        if (done_err != 0) begin
            bad++;
            $display("FAIL %s early_done: high in %0d cycles, required 0", name, done_err);
        end
        total++;
        if (bus.done !== 1'b1) begin
            bad++;
            $display("FAIL %s done: got %b, required 1", name, bus.done);
        end
        total++;
        if (bus.busy !== 1'b0) begin
            bad++;
            $display("FAIL %s busy_end: got %b, required 0", name, bus.busy);
        end
        total++;
        if ({bus.hi, bus.lo} !== exp) begin
            bad++;
            $display("FAIL %s result: got hi=%h lo=%h, required hi=%h lo=%h", name, bus.hi, bus.lo, exp[2*DW-1:DW], exp[DW-1:0]);
        end
        m_hi = exp[2*DW-1:DW];
        m_lo = exp[DW-1:0];
    endtask

    task automatic test_reset();
        total++;
        if ({bus.busy, bus.done, bus.hi, bus.lo} !== '0) begin
            bad++;
            $display("FAIL reset_state: got busy=%b done=%b hi=%h lo=%h, required all 0", bus.busy, bus.done, bus.hi, bus.lo);
        end
    endtask

    task automatic test_directed();
        run_op(OP_MULT, 32'hFFFF_FFFD, 32'd5, "mult_neg3x5");
        tick();
        total++;
        if (bus.done !== 1'b0) begin
            bad++;
            $display("FAIL done_one_cycle: got %b, required 0", bus.done);
        end
        run_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu_max");
        tick();
        run_op(OP_MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mult_m1xm1");
        tick();
        run_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, "div_neg7by2");
        tick();
        run_op(OP_DIVU, 32'd7, 32'd2, "divu_7by2");
        tick();
        run_op(OP_DIV, 32'd100, 32'd0, "div_by_zero");
        tick();
        run_op(OP_DIVU, 32'hF000_0001, 32'd0, "divu_by_zero");
        tick();
        run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, "div_overflow");
        tick();
    endtask

    task automatic test_back_to_back();
        run_op(OP_DIVU, 32'd1000, 32'd7, "b2b_first");
        run_op(OP_MULT, 32'h8000_0000, 32'd3, "b2b_second");
        tick();
    endtask

    task automatic test_mthi_mtlo();
        bus.start  = 1'b1;
        bus.op     = OP_MTHI;
        bus.data_a = 32'hA5A5_A5A5;
        tick();
        bus.start = 1'b0;
        total++;
        if (bus.hi !== 32'hA5A5_A5A5 || bus.lo !== m_lo || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            bad++;
            $display("FAIL mthi: got hi=%h lo=%h busy=%b done=%b, required hi=a5a5a5a5 lo=%h busy=0 done=0", bus.hi, bus.lo, bus.busy, bus.done, m_lo);
        end
        m_hi = 32'hA5A5_A5A5;
        bus.start  = 1'b1;
        bus.op     = OP_MTLO;
        bus.data_a = 32'h1234_5678;
        tick();
        bus.start = 1'b0;
        total++;
        if (bus.lo !== 32'h1234_5678 || bus.hi !== m_hi || bus.busy !== 1'b0) begin
            bad++;
            $display("FAIL mtlo: got hi=%h lo=%h busy=%b, required hi=%h lo=12345678 busy=0", bus.hi, bus.lo, bus.busy, m_hi);
        end
        m_lo = 32'h1234_5678;
        tick();
    endtask

    task automatic test_undefined_op();
        bus.start  = 1'b1;
        bus.op     = 3'b110;
        bus.data_a = 32'hDEAD_BEEF;
        bus.data_b = 32'd3;
        tick();
        bus.op = 3'b111;
        tick();
        bus.start = 1'b0;
        tick();
        total++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.hi !== m_hi || bus.lo !== m_lo) begin
            bad++;
            $display("FAIL undefined_op: got busy=%b done=%b hi=%h lo=%h, required busy=0 done=0 hi=%h lo=%h", bus.busy, bus.done, bus.hi, bus.lo, m_hi, m_lo);
        end
    endtask

    task automatic test_flush();
        int done_seen;
        bus.start  = 1'b1;
        bus.op     = OP_DIV;
        bus.data_a = 32'd50;
        bus.data_b = 32'd3;
        tick();
        bus.start = 1'b0;
        for (int k = 1; k < 10; k++) tick();
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        total++;
        if (bus.busy !== 1'b0) begin
            bad++;
            $display("FAIL flush_busy: got %b, required 0", bus.busy);
        end
        done_seen = 0;
        for (int k = 0; k < DW + 4; k++) begin
            tick();
            if (bus.done !== 1'b0) done_seen++;
        end
        total++;
        if (done_seen != 0) begin
            bad++;
            $display("FAIL flush_no_done: done high %0d cycles, required 0", done_seen);
        end
        total++;
        if (bus.hi !== m_hi || bus.lo !== m_lo) begin
            bad++;
            $display("FAIL flush_keep: got hi=%h lo=%h, required hi=%h lo=%h", bus.hi, bus.lo, m_hi, m_lo);
        end
        // flush alone in IDLE, then flush together with start in IDLE
        bus.flush = 1'b1;
        tick();
        bus.start  = 1'b1;
        bus.op     = OP_MTHI;
        bus.data_a = 32'h0BAD_F00D;
        tick();
        total++;
        if (bus.hi !== m_hi || bus.busy !== 1'b0) begin
            bad++;
            $display("FAIL flush_beats_mthi: got hi=%h busy=%b, required hi=%h busy=0", bus.hi, bus.busy, m_hi);
        end
        bus.op     = OP_MULT;
        bus.data_b = 32'd9;
        tick();
        bus.start = 1'b0;
        bus.flush = 1'b0;
        tick();
        total++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            bad++;
            $display("FAIL flush_beats_mult: got busy=%b done=%b, required 0 0", bus.busy, bus.done);
        end
    endtask

    task automatic test_start_while_busy();
        logic [2*DW-1:0] exp;
        exp        = ref_model(OP_MULTU, 32'd123_456, 32'd789);
        bus.start  = 1'b1;
        bus.op     = OP_MULTU;
        bus.data_a = 32'd123_456;
        bus.data_b = 32'd789;
        tick();
        bus.start = 1'b0;
        for (int k = 1; k <= DW + 2; k++) begin
            if (k == 5) begin
                bus.start  = 1'b1;
                bus.op     = OP_DIVU;
                bus.data_a = 32'd999;
                bus.data_b = 32'd5;
            end
            if (k == 7) bus.start = 1'b0;
            tick();
        end
        total++;
        if (bus.done !== 1'b1 || {bus.hi, bus.lo} !== exp) begin
            bad++;
            $display("FAIL start_while_busy: got done=%b hi=%h lo=%h, required done=1 hi=%h lo=%h", bus.done, bus.hi, bus.lo, exp[2*DW-1:DW], exp[DW-1:0]);
        end
        m_hi = exp[2*DW-1:DW];
        m_lo = exp[DW-1:0];
        tick();
        total++;
        if (bus.busy !== 1'b0) begin
            bad++;
            $display("FAIL start_while_busy_idle: got busy=%b, required 0", bus.busy);
        end
    endtask

    task automatic test_random();
        logic [2:0]    op;
        logic [DW-1:0] a, b;
        for (int i = 0; i < 30; i++) begin
            op = 3'($urandom_range(0, 3));
            a  = pick_operand();
            b  = pick_operand();
            run_op(op, a, b, $sformatf("rand%0d_op%0d_%h_%h", i, op, a, b));
            if ($urandom_range(0, 1) == 1) tick();
        end
        tick();
    endtask

    task automatic test_async_reset();
        bus.start  = 1'b1;
        bus.op     = OP_MULTU;
        bus.data_a = 32'd321;
        bus.data_b = 32'd654;
        tick();
        bus.start = 1'b0;
        for (int k = 0; k < 10; k++) tick();
        #3;
        rst_n = 1'b0;
        #1;
        total++;
        if (bus.hi !== '0 || bus.lo !== '0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            bad++;
            $display("FAIL async_reset: got hi=%h lo=%h busy=%b done=%b, required all 0", bus.hi, bus.lo, bus.busy, bus.done);
        end
        m_hi = '0;
        m_lo = '0;
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        tick();
        run_op(OP_MULTU, 32'd6, 32'd7, "multu_6x7_after_reset");
        tick();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.start  = 1'b0;
        bus.op     = 3'b000;
        bus.data_a = '0;
        bus.data_b = '0;
        bus.flush  = 1'b0;
        #12;
        rst_n = 1'b1;
        tick();
        test_reset();
        test_directed();
        test_back_to_back();
        test_mthi_mtlo();
        test_undefined_op();
        test_flush();
        test_start_while_busy();
        test_random();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mul_div_unit.md
Name: mul_div_unit

Overview:
- Iterative multiply/divide unit for the MIPS EX stage, parametrised in data width. Provides MULT/MULTU/DIV/DIVU and owns the HI/LO register pair.
- Works beside the combinational ALU. The hazard unit stalls on busy. MFHI/MFLO read the hi/lo outputs directly, and MTHI/MTLO write them.
- Radix-2 shift-add multiply and restoring divide, one bit per cycle.

Parameters:
- DATA_WIDTH, 32: operand, HI and LO width. Must be ≥4.
- OP_MULT, 3'b000: signed multiply.
- OP_MULTU, 3'b001: unsigned multiply.
- OP_DIV, 3'b010: signed divide.
- OP_DIVU, 3'b011: unsigned divide.
- OP_MTHI, 3'b100: write data_a to HI.
- OP_MTLO, 3'b101: write data_a to LO.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request, sampled on the rising edge.
- op  input  3  operation select, sampled with start.
- data_a  input  DATA_WIDTH  multiplicand / dividend / MTHI-MTLO source.
- data_b  input  DATA_WIDTH  multiplier / divisor.
- flush  input  1  synchronous abort of an in-flight operation.
- busy  output  1  high while an operation is in flight (state != IDLE).
- done  output  1  one-cycle pulse when HI/LO take a mul/div result.
- hi  output  DATA_WIDTH  HI register.
- lo  output  DATA_WIDTH  LO register.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE, hi=0, lo=0, done=0, busy=0, counter=0.
  - Applies at any point, including mid-operation; the in-flight result is lost.
- States: IDLE, PREP, RUN, FIX.
  - IDLE + start + mul/div op → PREP. Latch operands and the sign flags (signed ops only).
  - PREP (1 cycle) → RUN. Take absolute values for signed ops, clear the accumulator, load the counter with DATA_WIDTH.
  - RUN (DATA_WIDTH cycles) → FIX. Process one bit per cycle and decrement the counter. Leave on the cycle the counter reaches 1.
  - FIX (1 cycle) → IDLE. Apply sign correction, write hi/lo, register done=1.
- Latency:
  - Start sampled at edge N. hi/lo are updated and done=1 after edge N+DATA_WIDTH+2 (34 for 32-bit).
  - busy is high from edge N+1 until edge N+DATA_WIDTH+2, where it drops to 0 while done rises.
  - done is high for exactly one cycle.
- MTHI/MTLO:
  - With start in IDLE, write hi or lo from data_a at that edge.
  - No busy, no done; the other register is unchanged.
- Start handling:
  - start while busy is ignored; the operands are not relatched.
  - start with an undefined op (110, 111) is a no-op.
  - Back-to-back is allowed: start in the done cycle begins a new operation.
- Multiply:
  - {hi,lo} = full 2×DATA_WIDTH product.
  - Signed result is negated in FIX when the operand signs differ.
- Divide:
  - lo = quotient truncated toward zero; hi = remainder.
  - Signed: quotient negative when the signs differ; the remainder takes the dividend's sign.
- Division by zero (signed or unsigned): lo = all ones, hi = dividend. Still full latency with done.
- Signed overflow (most-negative / −1): lo = most-negative value, hi = 0.
- Flush:
  - In any non-IDLE state, go to IDLE at the next edge. busy=0 after that edge; hi/lo unchanged; no done.
  - flush together with start in IDLE: flush wins and nothing is accepted, including MTHI/MTLO.
  - flush in IDLE is a no-op.
- Arithmetic: the internal accumulator is 2×DATA_WIDTH (+1 for the divide subtract); the counter is $clog2(DATA_WIDTH)+1 bits.

Test Plan:
- Reset then MULT, data_a=0xFFFFFFFD (−3), data_b=5 → busy high 33 cycles; after edge 34, hi=0xFFFFFFFF, lo=0xFFFFFFF1, done one cycle.
- MULTU 0xFFFFFFFF×0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001. MULT of the same operands → hi=0, lo=1.
- DIV −7/2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIVU 7/2 → lo=3, hi=1.
- DIV 100/0 → lo=0xFFFFFFFF, hi=0x00000064.
- DIV 0x80000000/0xFFFFFFFF → lo=0x80000000, hi=0.
- Flush and abort cases:
  - Start DIV 50/3, flush at cycle 10 → busy=0 next cycle, hi/lo keep prior values, no done.
  - MTHI 0xA5A5A5A5 → hi updates next edge, busy stays 0.
  - A second start during busy → ignored; the first result completes.
- rst_n low mid-operation, asynchronously between edges → hi=lo=0, busy=0 immediately. A later MULTU 6×7 → lo=42, hi=0.
